abro_rendezvous_ctrl: RTL and testbench

Parameterised rendezvous controller generalising the two-input a/b arrival FSM to N requesters. It records which requesters have pulsed in any order, including simultaneously. Once all N have arrived it raises `z` and holds it until the downstream consumer acknowledges. An abort input (R) and a programmable arrival timeout return the block to idle, so one stalled requester cannot hang the sequence.

---
 rtl/abro_pkg.sv | 14 +
 rtl/abro_timer.sv | 27 ++
 rtl/abro_rendezvous_ctrl.sv | 102 ++++++++++
 tb/tb_abro_rendezvous_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/abro_pkg.sv
// Shared definitions for the a/b arrival FSM family: state encoding and
// handshake counter width.
package abro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FIRE    = 2'd2,
    ST_TOUT    = 2'd3
  } abro_state_e;

  localparam int FIRE_CNT_W = 8;

endpackage

// File: rtl/abro_timer.sv
// Arrival timeout counter: counts while enabled, flags the last allowed cycle.
// A TMO_MAX of zero disables expiry entirely.
module abro_timer #(
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic clk,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TMO_W-1:0] LP_LAST = (TMO_MAX == 0) ? '0 : TMO_W'(TMO_MAX - 1);

  logic [TMO_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + TMO_W'(1);
    end
  end

  assign expired = (TMO_MAX != 0) && (r_count == LP_LAST);

endmodule

// File: rtl/abro_rendezvous_ctrl.sv
// N-way rendezvous: collects requester arrivals in any order, raises z once
// all have arrived and holds it until ack; clr or a timeout abandon the round.
module abro_rendezvous_ctrl
  import abro_pkg::*;
#(
  parameter int N       = 2,
  parameter int TMO_W   = 8,
  parameter int TMO_MAX = 200
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req,
  input  logic                  clr,
  input  logic                  ack,
  output logic                  z,
  output logic [N-1:0]          seen,
  output logic                  busy,
  output logic                  timeout,
  output logic [FIRE_CNT_W-1:0] fire_cnt
);

  abro_state_e           r_state;
  logic [N-1:0]          r_seen;
  logic [FIRE_CNT_W-1:0] r_fire_cnt;

  logic [N-1:0] w_nxt;
  logic         w_all;
  logic         w_req_all;
  logic         w_expired;
  logic         w_tmr_clr;
  logic         w_tmr_en;

  assign w_nxt     = r_seen | req;
  assign w_all     = &w_nxt;
  assign w_req_all = &req;

  // Timer only runs in COLLECT; leaving COLLECT rearms it to zero so the
  // next round always starts counting from the first arrival edge.
  assign w_tmr_clr = reset || clr || (r_state != ST_COLLECT);
  assign w_tmr_en  = (r_state == ST_COLLECT) && !w_all && !w_expired;

  abro_timer #(
    .TMO_W  (TMO_W),
    .TMO_MAX(TMO_MAX)
  ) u_timer (
    .clk    (clk),
    .clr    (w_tmr_clr),
    .en     (w_tmr_en),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_seen     <= '0;
      r_fire_cnt <= '0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_seen  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req != '0) begin
            r_seen  <= req;
            r_state <= w_req_all ? ST_FIRE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          // Completion beats expiry when both land on the same edge.
          r_seen <= w_nxt;
          if (w_all) begin
            r_state <= ST_FIRE;
          end else if (w_expired) begin
            r_state <= ST_TOUT;
          end
        end
        ST_FIRE: begin
          if (ack) begin
            r_seen     <= '0;
            r_fire_cnt <= r_fire_cnt + FIRE_CNT_W'(1);
            r_state    <= ST_IDLE;
          end
        end
        ST_TOUT: begin
          r_seen  <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_seen  <= '0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign z        = (r_state == ST_FIRE);
  assign busy     = (r_state == ST_COLLECT) || (r_state == ST_FIRE);
  assign timeout  = (r_state == ST_TOUT);
  assign seen     = r_seen;
  assign fire_cnt = r_fire_cnt;

endmodule

// File: tb/tb_abro_rendezvous_ctrl.sv
// Directed bench: a 2-requester instance with a 5-cycle timeout and a
// 4-requester instance with the timeout disabled.
module tb_abro_rendezvous_ctrl;

  logic clk = 1'b0;
  logic reset;

  logic [1:0] a_req;
  logic       a_clr, a_ack;
  logic       a_z, a_busy, a_timeout;
  logic [1:0] a_seen;
  logic [7:0] a_fire_cnt;

  logic [3:0] b_req;
  logic       b_clr, b_ack;
  logic       b_z, b_busy, b_timeout;
  logic [3:0] b_seen;
  logic [7:0] b_fire_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  abro_rendezvous_ctrl #(.N(2), .TMO_W(8), .TMO_MAX(5)) u_a (
    .clk(clk), .reset(reset), .req(a_req), .clr(a_clr), .ack(a_ack),
    .z(a_z), .seen(a_seen), .busy(a_busy), .timeout(a_timeout), .fire_cnt(a_fire_cnt)
  );

  abro_rendezvous_ctrl #(.N(4), .TMO_W(8), .TMO_MAX(0)) u_b (
    .clk(clk), .reset(reset), .req(b_req), .clr(b_clr), .ack(b_ack),
    .z(b_z), .seen(b_seen), .busy(b_busy), .timeout(b_timeout), .fire_cnt(b_fire_cnt)
  );

  // Advance one rising edge and settle before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    a_req = '0; a_clr = 1'b0; a_ack = 1'b0;
    b_req = '0; b_clr = 1'b0; b_ack = 1'b0;
    step(); step();
    reset = 1'b0;
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen, a_fire_cnt} !== 13'h0) begin
      n_errors++;
      $display("FAIL reset_a: got %h required %h", {a_z, a_busy, a_timeout, a_seen, a_fire_cnt}, 13'h0);
    end
    n_checks++;
    if ({b_z, b_busy, b_timeout, b_seen, b_fire_cnt} !== 15'h0) begin
      n_errors++;
      $display("FAIL reset_b: got %h required %h", {b_z, b_busy, b_timeout, b_seen, b_fire_cnt}, 15'h0);
    end
    $display("test_reset done");
  endtask

  // Flags below are packed as {z, busy, timeout, seen}.
  task automatic test_basic();
    a_req = 2'b01; step();
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen} !== 5'b0_1_0_01) begin
      n_errors++;
      $display("FAIL basic_first: got %b required %b", {a_z, a_busy, a_timeout, a_seen}, 5'b0_1_0_01);
    end
    a_req = 2'b00; step(); step();
    a_req = 2'b10; step();
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen} !== 5'b1_1_0_11) begin
      n_errors++;
      $display("FAIL basic_fire: got %b required %b", {a_z, a_busy, a_timeout, a_seen}, 5'b1_1_0_11);
    end
    a_req = 2'b00; step(); step();
    n_checks++;
    if (a_z !== 1'b1) begin
      n_errors++;
      $display("FAIL basic_hold: z=%b required 1", a_z);
    end
    a_ack = 1'b1; step();
    a_ack = 1'b0;
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen, a_fire_cnt} !== {5'b0_0_0_00, 8'd1}) begin
      n_errors++;
      $display("FAIL basic_ack: got %h required %h", {a_z, a_busy, a_timeout, a_seen, a_fire_cnt}, {5'b0_0_0_00, 8'd1});
    end
    $display("test_basic done fire_cnt=%0d", a_fire_cnt);
  endtask

  task automatic test_back_to_back();
    a_req = 2'b11; a_ack = 1'b1; step();
    n_checks++;
    if ({a_z, a_fire_cnt} !== {1'b1, 8'd1}) begin
      n_errors++;
      $display("FAIL b2b_fire1: got %h required %h", {a_z, a_fire_cnt}, {1'b1, 8'd1});
    end
    a_req = 2'b00; step();
    n_checks++;
    if ({a_z, a_fire_cnt} !== {1'b0, 8'd2}) begin
      n_errors++;
      $display("FAIL b2b_ack1: got %h required %h", {a_z, a_fire_cnt}, {1'b0, 8'd2});
    end
    a_req = 2'b11; step();
    n_checks++;
    if (a_z !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_fire2: z=%b required 1", a_z);
    end
    a_req = 2'b00; step();
    a_ack = 1'b0;
    n_checks++;
    if ({a_z, a_busy, a_fire_cnt} !== {2'b00, 8'd3}) begin
      n_errors++;
      $display("FAIL b2b_ack2: got %h required %h", {a_z, a_busy, a_fire_cnt}, {2'b00, 8'd3});
    end
    $display("test_back_to_back done fire_cnt=%0d", a_fire_cnt);
  endtask

  task automatic test_timeout();
    a_req = 2'b01; step();
    a_req = 2'b00;
    repeat (4) step();
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen} !== 5'b0_1_0_01) begin
      n_errors++;
      $display("FAIL tmo_before: got %b required %b", {a_z, a_busy, a_timeout, a_seen}, 5'b0_1_0_01);
    end
    step();
    n_checks++;
    if ({a_z, a_busy, a_timeout} !== 3'b0_0_1) begin
      n_errors++;
      $display("FAIL tmo_pulse: got %b required %b", {a_z, a_busy, a_timeout}, 3'b0_0_1);
    end
    a_req = 2'b10; step();
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen} !== 5'b0_0_0_00) begin
      n_errors++;
      $display("FAIL tmo_idle: got %b required %b", {a_z, a_busy, a_timeout, a_seen}, 5'b0_0_0_00);
    end
    a_req = 2'b00; step();
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen, a_fire_cnt} !== {5'b0_0_0_00, 8'd3}) begin
      n_errors++;
      $display("FAIL tmo_ignored: got %h required %h", {a_z, a_busy, a_timeout, a_seen, a_fire_cnt}, {5'b0_0_0_00, 8'd3});
    end
    $display("test_timeout done");
  endtask

  task automatic test_race();
    a_req = 2'b01; step();
    a_req = 2'b00;
    repeat (4) step();
    a_req = 2'b10; step();
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen} !== 5'b1_1_0_11) begin
      n_errors++;
      $display("FAIL race_fire: got %b required %b", {a_z, a_busy, a_timeout, a_seen}, 5'b1_1_0_11);
    end
    a_req = 2'b00; a_ack = 1'b1; step();
    a_ack = 1'b0;
    n_checks++;
    if ({a_z, a_timeout, a_fire_cnt} !== {2'b00, 8'd4}) begin
      n_errors++;
      $display("FAIL race_ack: got %h required %h", {a_z, a_timeout, a_fire_cnt}, {2'b00, 8'd4});
    end
    $display("test_race done fire_cnt=%0d", a_fire_cnt);
  endtask

  task automatic test_clr();
    a_req = 2'b11; step();
    a_req = 2'b00; a_clr = 1'b1; step();
    a_clr = 1'b0;
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen, a_fire_cnt} !== {5'b0_0_0_00, 8'd4}) begin
      n_errors++;
      $display("FAIL clr_fire: got %h required %h", {a_z, a_busy, a_timeout, a_seen, a_fire_cnt}, {5'b0_0_0_00, 8'd4});
    end
    a_ack = 1'b1; step();
    a_ack = 1'b0;
    n_checks++;
    if (a_fire_cnt !== 8'd4) begin
      n_errors++;
      $display("FAIL ack_idle: fire_cnt=%0d required 4", a_fire_cnt);
    end
    a_req = 2'b01; step();
    a_req = 2'b00; reset = 1'b1; step();
    reset = 1'b0;
    n_checks++;
    if ({a_z, a_busy, a_timeout, a_seen, a_fire_cnt} !== 13'h0) begin
      n_errors++;
      $display("FAIL reset_mid: got %h required %h", {a_z, a_busy, a_timeout, a_seen, a_fire_cnt}, 13'h0);
    end
    $display("test_clr done");
  endtask

  task automatic test_wrap();
    a_ack = 1'b1;
    for (int i = 0; i < 255; i++) begin
      a_req = 2'b11; step();
      a_req = 2'b00; step();
    end
    n_checks++;
    if (a_fire_cnt !== 8'd255) begin
      n_errors++;
      $display("FAIL wrap_255: fire_cnt=%0d required 255", a_fire_cnt);
    end
    a_req = 2'b11; step();
    a_req = 2'b00; step();
    a_ack = 1'b0;
    n_checks++;
    if ({a_busy, a_fire_cnt} !== 9'd0) begin
      n_errors++;
      $display("FAIL wrap_0: got %h required %h", {a_busy, a_fire_cnt}, 9'd0);
    end
    $display("test_wrap done fire_cnt=%0d", a_fire_cnt);
  endtask

  task automatic test_no_timeout();
    logic saw_tout;
    saw_tout = 1'b0;
    b_req = 4'b0101; step();
    b_req = 4'b0010; step();
    b_req = 4'b0001; step();
    n_checks++;
    if ({b_z, b_busy, b_seen} !== 6'b0_1_0111) begin
      n_errors++;
      $display("FAIL notmo_collect: got %b required %b", {b_z, b_busy, b_seen}, 6'b0_1_0111);
    end
    b_req = 4'b0000;
    for (int i = 0; i < 1000; i++) begin
      step();
      saw_tout = saw_tout | b_timeout | ~b_busy;
    end
    n_checks++;
    if (saw_tout !== 1'b0) begin
      n_errors++;
      $display("FAIL notmo_hold: timeout_or_idle_seen=%b required 0", saw_tout);
    end
    b_req = 4'b1000; step();
    b_req = 4'b0000;
    n_checks++;
    if ({b_z, b_busy, b_timeout, b_seen} !== 7'b1_1_0_1111) begin
      n_errors++;
      $display("FAIL notmo_fire: got %b required %b", {b_z, b_busy, b_timeout, b_seen}, 7'b1_1_0_1111);
    end
    b_ack = 1'b1; step();
    b_ack = 1'b0;
    n_checks++;
    if ({b_z, b_busy, b_seen, b_fire_cnt} !== {6'b0_0_0000, 8'd1}) begin
      n_errors++;
      $display("FAIL notmo_ack: got %h required %h", {b_z, b_busy, b_seen, b_fire_cnt}, {6'b0_0_0000, 8'd1});
    end
    $display("test_no_timeout done fire_cnt=%0d", b_fire_cnt);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_timeout();
    test_race();
    test_clr();
    test_wrap();
    test_no_timeout();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
